// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read-address arbiter and the bridge around it:
// AR ids, transfer size encodings and the grant selector.
package axi_rd_arbiter_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } grant_e;

    function automatic logic [2:0] ar_size_of(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/rd_wr_scoreboard.sv
// In-order circular FIFO of pending write word addresses with a parallel
// compare port; hit means the queried word still has a write in flight.
module rd_wr_scoreboard
    import axi_rd_arbiter_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [29:0]      push_addr,
    input  logic             pop,
    input  logic [29:0]      query_addr,
    output logic             hit,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [29:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_en, pop_en;
    logic [DEPTH-1:0] hit_vec;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign push_en = push && !full;
    assign pop_en  = pop && (count_q != '0);

    // An entry is live when its distance from the read pointer is below count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [PTR_W-1:0] offs;
        assign offs        = PTR_W'(gi) - rd_ptr_q;
        assign hit_vec[gi] = ({1'b0, offs} < count_q) && (mem_q[gi] == query_addr);
    end
    assign hit = |hit_vec;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_addr;
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction fetch and data load onto one AR register stage,
// tracks outstanding reads per port and holds data reads that hit a pending write.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int MAX_OUT      = 4,
    parameter int WR_DEPTH     = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s0_req,
    input  logic [31:0] s0_addr,
    input  logic [1:0]  s0_size,
    output logic        s0_addr_ok,
    output logic        s0_data_ok,
    input  logic        s1_req,
    input  logic [31:0] s1_addr,
    input  logic [1:0]  s1_size,
    output logic        s1_addr_ok,
    output logic        s1_data_ok,
    output logic        ar_valid,
    output logic [3:0]  ar_id,
    output logic [31:0] ar_addr,
    output logic [2:0]  ar_size,
    input  logic        ar_ready,
    input  logic        r_done,
    input  logic [3:0]  r_id,
    input  logic        wr_push,
    input  logic [31:0] wr_push_addr,
    input  logic        b_done,
    output logic        wr_full,
    output logic [2:0]  wr_pending
);

    localparam int SB_CNT_W = $clog2(WR_DEPTH) + 1;
    localparam int ST_W     = $clog2(STARVE_LIMIT + 1);

    logic          ar_valid_q, ar_valid_d;
    logic [3:0]    ar_id_q, ar_id_d;
    logic [31:0]   ar_addr_q, ar_addr_d;
    logic [2:0]    ar_size_q, ar_size_d;
    logic [3:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [ST_W-1:0] starve_q, starve_d;

    logic          ld, s0_elig, s1_elig, hazard, sb_hit, done0, done1;
    logic [SB_CNT_W-1:0] sb_count;
    grant_e        gnt;

    rd_wr_scoreboard #(.DEPTH(WR_DEPTH)) u_sb (
        .clk        (clk),
        .resetn     (resetn),
        .push       (wr_push),
        .push_addr  (wr_push_addr[31:2]),
        .pop        (b_done),
        .query_addr (s1_addr[31:2]),
        .hit        (sb_hit),
        .full       (wr_full),
        .count      (sb_count)
    );

    // A write accepted this very cycle is not yet in the scoreboard, so compare it directly.
    assign hazard  = sb_hit || (wr_push && (wr_push_addr[31:2] == s1_addr[31:2]));
    assign ld      = !ar_valid_q || ar_ready;
    assign s0_elig = resetn && s0_req && (cnt0_q < 4'(MAX_OUT));
    assign s1_elig = resetn && s1_req && (cnt1_q < 4'(MAX_OUT)) && !hazard;
    assign done0   = resetn && r_done && (r_id == ID_INST) && (cnt0_q != '0);
    assign done1   = resetn && r_done && (r_id == ID_DATA) && (cnt1_q != '0);

    always_comb begin
        gnt        = GNT_NONE;
        ar_valid_d = ar_valid_q;
        ar_id_d    = ar_id_q;
        ar_addr_d  = ar_addr_q;
        ar_size_d  = ar_size_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        starve_d   = starve_q;

        if (ld) begin
            if (s1_elig && !(s0_elig && starve_q >= ST_W'(STARVE_LIMIT))) gnt = GNT_DATA;
            else if (s0_elig)                                            gnt = GNT_INST;
        end

        case (gnt)
            GNT_INST: begin
                ar_valid_d = 1'b1;
                ar_id_d    = ID_INST;
                ar_addr_d  = s0_addr;
                ar_size_d  = ar_size_of(s0_size);
            end
            GNT_DATA: begin
                ar_valid_d = 1'b1;
                ar_id_d    = ID_DATA;
                ar_addr_d  = s1_addr;
                ar_size_d  = ar_size_of(s1_size);
            end
            default: if (ld) ar_valid_d = 1'b0;
        endcase

        case ({gnt == GNT_INST, done0})
            2'b10:   cnt0_d = cnt0_q + 1'b1;
            2'b01:   cnt0_d = cnt0_q - 1'b1;
            default: cnt0_d = cnt0_q;
        endcase
        case ({gnt == GNT_DATA, done1})
            2'b10:   cnt1_d = cnt1_q + 1'b1;
            2'b01:   cnt1_d = cnt1_q - 1'b1;
            default: cnt1_d = cnt1_q;
        endcase

        if (gnt == GNT_INST || !s0_req)
            starve_d = '0;
        else if (gnt == GNT_DATA && s0_elig && starve_q < ST_W'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_size_q  <= '0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            starve_q   <= '0;
        end else begin
            ar_valid_q <= ar_valid_d;
            ar_id_q    <= ar_id_d;
            ar_addr_q  <= ar_addr_d;
            ar_size_q  <= ar_size_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            starve_q   <= starve_d;
        end
    end

    assign s0_addr_ok = (gnt == GNT_INST);
    assign s1_addr_ok = (gnt == GNT_DATA);
    assign s0_data_ok = done0;
    assign s1_data_ok = done1;
    assign ar_valid   = ar_valid_q;
    assign ar_id      = ar_id_q;
    assign ar_addr    = ar_addr_q;
    assign ar_size    = ar_size_q;
    assign wr_pending = 3'(sb_count);

endmodule
